// File: rtl/c6502_memctl.sv
// c6502 bus responder: internal byte RAM below 2^RAM_AW, external req/ack
// port above it, and one `ce` pulse per completed CPU slot.
//
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   address, din, we, rd   CPU request (rd is informational only)
//   dout, ce               read data and clock enable back to the CPU
//   ext_addr, ext_dout,    external request port; ext_req is held
//   ext_we, ext_req        until ext_ack
//   ext_din, ext_ack       external read data and acknowledge
//   bus_err                sticky external timeout flag
//
// Optional feature: define C6502_MEMCTL_WATCHDOG_EN to abort external
// slots after TIMEOUT wait clocks (read data FF, write dropped).
// Without it bus_err is constant 0 and S_WAIT waits indefinitely.

module c6502_memctl #(
  parameter int RAM_AW  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  input  logic        we,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        ce,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  output logic        ext_we,
  output logic        ext_req,
  input  logic [7:0]  ext_din,
  input  logic        ext_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_ADDR,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic              internal;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        mem [2**RAM_AW];
  logic [7:0]        ram_q;
  logic              sel_ram;
  logic [7:0]        dout_q;
  logic              timeout;
  logic              unused_rd;

  assign unused_rd = rd;
  assign internal  = (address[15:RAM_AW] == '0);
  assign ram_idx   = address[RAM_AW-1:0];

  // An internal read lands in ram_q one clock after S_ADDR; instead of
  // copying it into dout_q (one clock too late) the output is steered to
  // ram_q until another slot produces data. ram_q only moves on internal
  // reads, so it holds stable between S_DONE cycles like dout_q does.
  assign dout = sel_ram ? ram_q : dout_q;

`ifdef C6502_MEMCTL_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          bus_err_q;

  assign timeout = (state == S_WAIT) && (wd_cnt == CW'(TIMEOUT - 1));
  assign bus_err = bus_err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      // ack in the same clock as the timeout wins
      if (timeout && !ext_ack) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_ADDR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ce       = 1'b0;
    unique case (state)
      S_ADDR: state_nx = internal ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (ext_ack || timeout) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        ce       = 1'b1;
        state_nx = S_ADDR;
      end
      default: state_nx = S_ADDR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dout_q   <= 8'h00;
      sel_ram  <= 1'b0;
      ext_req  <= 1'b0;
      ext_we   <= 1'b0;
      ext_addr <= 16'h0000;
      ext_dout <= 8'h00;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (internal) begin
            sel_ram <= !we;
            if (we) begin
              dout_q <= din;
            end
          end else begin
            ext_req  <= 1'b1;
            ext_addr <= address;
            ext_we   <= we;
            ext_dout <= din;
          end
        end
        S_WAIT: begin
          // ext_we/ext_dout still hold the latched slot, so they double
          // as the write flag and write data for the completion value.
          if (ext_ack) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            sel_ram <= 1'b0;
            dout_q  <= ext_we ? ext_dout : ext_din;
          end else if (timeout) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
            sel_ram <= 1'b0;
            dout_q  <= ext_we ? ext_dout : 8'hFF;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM has no reset: contents survive reset_n.
  always_ff @(posedge clock) begin
    if (state == S_ADDR && internal) begin
      if (we) begin
        mem[ram_idx] <= din;
      end else begin
        ram_q <= mem[ram_idx];
      end
    end
  end

endmodule
